// File: rtl/digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : digit_entry
//  Purpose  : Keypad digit collector. Assembles a 4-digit username followed
//             by a 4-digit password, one decimal digit per strobe, and
//             presents the digits plus a running count to the unlocker.
//  Options  : DIGIT_ENTRY_TIMEOUT_EN - when defined, a partial entry idle for
//             TIMEOUT_CYCLES cycles is discarded and timeoutClr pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_entry #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int TIMEOUT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digitValid,
    input  logic [3:0] digitValue,
    input  logic       backspace,
    input  logic       clearEntry,
    input  logic       resetCount,
    output logic [3:0] inputCount,
    output logic [3:0] userNameInput0,
    output logic [3:0] userNameInput1,
    output logic [3:0] userNameInput2,
    output logic [3:0] userNameInput3,
    output logic [3:0] passwordInput0,
    output logic [3:0] passwordInput1,
    output logic [3:0] passwordInput2,
    output logic [3:0] passwordInput3,
    output logic       entryDone,
    output logic       digitReject,
    output logic       timeoutClr
);

    // Entry phase, derived from the count register rather than stored.
    localparam logic [1:0] c_STATE_USER = 2'd0;
    localparam logic [1:0] c_STATE_PASS = 2'd1;
    localparam logic [1:0] c_STATE_FULL = 2'd2;

    logic [3:0] r_count;
    logic [3:0] r_slot [8];
    logic       r_entryDone;
    logic       r_digitReject;
    logic       r_timeoutClr;

    logic [1:0] w_state;
    logic       w_timeoutHit;
    logic       w_clear;
    logic       w_doBackspace;
    logic       w_accept;
    logic       w_reject;
    logic [2:0] w_wrIdx;
    logic [2:0] w_bsIdx;

    // Decode the entry phase from the count.
    always_comb begin
        w_state = c_STATE_USER;
        if (r_count[3]) begin
            w_state = c_STATE_FULL;
        end else if (r_count[2]) begin
            w_state = c_STATE_PASS;
        end
    end

    // Slot indices: the next free slot, and the slot freed by a backspace.
    // A backspace from FULL (count 8) wraps 0-1 to slot 7, as intended.
    assign w_wrIdx = r_count[2:0];
    assign w_bsIdx = r_count[2:0] - 3'd1;

    // One event per cycle, resolved in priority order. Clears outrank
    // backspace, which outranks a digit strobe.
    assign w_clear       = resetCount | clearEntry | w_timeoutHit;
    assign w_doBackspace = ~w_clear & backspace & (r_count != 4'd0);
    assign w_accept      = ~w_clear & ~backspace & digitValid &
                           (digitValue <= 4'd9) & (w_state != c_STATE_FULL);
    assign w_reject      = digitValid & ~w_accept;

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_idle;

    // Idle counter: runs only while a partial or full entry is held and
    // restarts on any accepted activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if ((r_count == 4'd0) || w_accept || w_doBackspace || w_clear) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_timeoutHit = (r_count != 4'd0) &&
                          (r_idle == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: configuration parameters are intentionally inert.
    logic [TIMEOUT_W-1:0] w_unusedTimeoutCfg;
    assign w_unusedTimeoutCfg = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign w_timeoutHit       = 1'b0;
`endif

    // Count, digit slots and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= '0;
            end
            r_entryDone   <= 1'b0;
            r_digitReject <= 1'b0;
            r_timeoutClr  <= 1'b0;
        end else begin
            r_entryDone   <= 1'b0;
            r_digitReject <= w_reject;
            r_timeoutClr  <= w_timeoutHit & ~resetCount & ~clearEntry;
            if (w_clear) begin
                r_count <= '0;
                for (int i = 0; i < 8; i++) begin
                    r_slot[i] <= '0;
                end
            end else if (w_doBackspace) begin
                r_count         <= r_count - 4'd1;
                r_slot[w_bsIdx] <= '0;
            end else if (w_accept) begin
                r_count         <= r_count + 4'd1;
                r_slot[w_wrIdx] <= digitValue;
                r_entryDone     <= (r_count == 4'd7);
            end
        end
    end

    assign inputCount     = r_count;
    assign userNameInput0 = r_slot[0];
    assign userNameInput1 = r_slot[1];
    assign userNameInput2 = r_slot[2];
    assign userNameInput3 = r_slot[3];
    assign passwordInput0 = r_slot[4];
    assign passwordInput1 = r_slot[5];
    assign passwordInput2 = r_slot[6];
    assign passwordInput3 = r_slot[7];
    assign entryDone      = r_entryDone;
    assign digitReject    = r_digitReject;
    assign timeoutClr     = r_timeoutClr;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_entry
//  Purpose  : Directed self-checking bench for digit_entry. Timeout checks
//             adapt to whether DIGIT_ENTRY_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digit_entry;

    logic       clk;
    logic       rst;
    logic       digitValid;
    logic [3:0] digitValue;
    logic       backspace;
    logic       clearEntry;
    logic       resetCount;
    logic [3:0] inputCount;
    logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
    logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
    logic       entryDone;
    logic       digitReject;
    logic       timeoutClr;

    int nCmp = 0;
    int nErr = 0;

    digit_entry #(
        .TIMEOUT_CYCLES(10),
        .TIMEOUT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digitValid    (digitValid),
        .digitValue    (digitValue),
        .backspace     (backspace),
        .clearEntry    (clearEntry),
        .resetCount    (resetCount),
        .inputCount    (inputCount),
        .userNameInput0(userNameInput0),
        .userNameInput1(userNameInput1),
        .userNameInput2(userNameInput2),
        .userNameInput3(userNameInput3),
        .passwordInput0(passwordInput0),
        .passwordInput1(passwordInput1),
        .passwordInput2(passwordInput2),
        .passwordInput3(passwordInput3),
        .entryDone     (entryDone),
        .digitReject   (digitReject),
        .timeoutClr    (timeoutClr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All eight slots packed in entry order: u0 u1 u2 u3 p0 p1 p2 p3.
    function automatic logic [31:0] slots();
        return {userNameInput0, userNameInput1, userNameInput2, userNameInput3,
                passwordInput0, passwordInput1, passwordInput2, passwordInput3};
    endfunction

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pressDigit(input logic [3:0] v);
        digitValid = 1'b1;
        digitValue = v;
        tick();
        digitValid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nCmp++;
        if (inputCount !== 4'd0) begin
            nErr++; $display("FAIL reset_count got=%0d exp=0", inputCount);
        end
        nCmp++;
        if (slots() !== 32'h0) begin
            nErr++; $display("FAIL reset_slots got=%h exp=00000000", slots());
        end
        nCmp++;
        if ({entryDone, digitReject, timeoutClr} !== 3'b000) begin
            nErr++; $display("FAIL reset_pulses got=%b exp=000", {entryDone, digitReject, timeoutClr});
        end
    endtask

    task automatic test_fill();
        logic [3:0] seq [8];
        seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
        doReset();
        for (int i = 0; i < 8; i++) begin
            pressDigit(seq[i]);
            nCmp++;
            if (inputCount !== 4'(i + 1)) begin
                nErr++; $display("FAIL fill_count step=%0d got=%0d exp=%0d", i, inputCount, i + 1);
            end
            nCmp++;
            if (entryDone !== (i == 7)) begin
                nErr++; $display("FAIL fill_done step=%0d got=%b exp=%b", i, entryDone, (i == 7));
            end
        end
        nCmp++;
        if (slots() !== 32'h0011_0011) begin
            nErr++; $display("FAIL fill_slots got=%h exp=00110011", slots());
        end
    endtask

    task automatic test_full();
        pressDigit(4'd5);
        nCmp++;
        if (digitReject !== 1'b1 || inputCount !== 4'd8 || entryDone !== 1'b0) begin
            nErr++; $display("FAIL full_reject rej=%b cnt=%0d done=%b exp rej=1 cnt=8 done=0",
                             digitReject, inputCount, entryDone);
        end
        backspace = 1'b1;
        tick();
        backspace = 1'b0;
        nCmp++;
        if (inputCount !== 4'd7 || passwordInput3 !== 4'd0 || digitReject !== 1'b0) begin
            nErr++; $display("FAIL full_backspace cnt=%0d p3=%0d rej=%b exp cnt=7 p3=0 rej=0",
                             inputCount, passwordInput3, digitReject);
        end
        pressDigit(4'd9);
        nCmp++;
        if (inputCount !== 4'd8 || passwordInput3 !== 4'd9 || entryDone !== 1'b1) begin
            nErr++; $display("FAIL full_refill cnt=%0d p3=%0d done=%b exp cnt=8 p3=9 done=1",
                             inputCount, passwordInput3, entryDone);
        end
        tick();
        nCmp++;
        if (entryDone !== 1'b0) begin
            nErr++; $display("FAIL full_done_width got=%b exp=0", entryDone);
        end
    endtask

    task automatic test_count3();
        doReset();
        pressDigit(4'd1);
        pressDigit(4'd2);
        pressDigit(4'd3);
        pressDigit(4'd12);
        nCmp++;
        if (digitReject !== 1'b1 || inputCount !== 4'd3) begin
            nErr++; $display("FAIL illegal_digit rej=%b cnt=%0d exp rej=1 cnt=3", digitReject, inputCount);
        end
        nCmp++;
        if (slots() !== 32'h1230_0000) begin
            nErr++; $display("FAIL illegal_digit_slots got=%h exp=12300000", slots());
        end
        digitValid = 1'b1;
        digitValue = 4'd7;
        backspace  = 1'b1;
        tick();
        digitValid = 1'b0;
        backspace  = 1'b0;
        nCmp++;
        if (inputCount !== 4'd2 || userNameInput2 !== 4'd0 || digitReject !== 1'b1) begin
            nErr++; $display("FAIL bs_vs_digit cnt=%0d u2=%0d rej=%b exp cnt=2 u2=0 rej=1",
                             inputCount, userNameInput2, digitReject);
        end
    endtask

    task automatic test_reset_count();
        int rejects;
        doReset();
        for (int i = 1; i <= 6; i++) pressDigit(4'(i));
        rejects    = 0;
        resetCount = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            digitValid = (c == 2);
            digitValue = 4'd5;
            tick();
            if (digitReject) rejects++;
        end
        digitValid = 1'b0;
        resetCount = 1'b0;
        tick();
        if (digitReject) rejects++;
        nCmp++;
        if (inputCount !== 4'd0 || slots() !== 32'h0) begin
            nErr++; $display("FAIL rc_clear cnt=%0d slots=%h exp cnt=0 slots=00000000", inputCount, slots());
        end
        nCmp++;
        if (rejects !== 1) begin
            nErr++; $display("FAIL rc_reject_count got=%0d exp=1", rejects);
        end
        pressDigit(4'd4);
        nCmp++;
        if (userNameInput0 !== 4'd4 || inputCount !== 4'd1) begin
            nErr++; $display("FAIL rc_after u0=%0d cnt=%0d exp u0=4 cnt=1", userNameInput0, inputCount);
        end
    endtask

    task automatic test_clear();
        doReset();
        pressDigit(4'd8);
        pressDigit(4'd7);
        pressDigit(4'd6);
        clearEntry = 1'b1;
        tick();
        clearEntry = 1'b0;
        nCmp++;
        if (inputCount !== 4'd0 || slots() !== 32'h0 || digitReject !== 1'b0) begin
            nErr++; $display("FAIL clear_entry cnt=%0d slots=%h rej=%b exp cnt=0 slots=0 rej=0",
                             inputCount, slots(), digitReject);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        doReset();
        pressDigit(4'd2);
        pressDigit(4'd3);
`ifdef DIGIT_ENTRY_TIMEOUT_EN
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (timeoutClr) pulses++;
        end
        nCmp++;
        if (inputCount !== 4'd2 || pulses !== 0) begin
            nErr++; $display("FAIL timeout_early cnt=%0d pulses=%0d exp cnt=2 pulses=0", inputCount, pulses);
        end
        tick();
        nCmp++;
        if (inputCount !== 4'd0 || slots() !== 32'h0 || timeoutClr !== 1'b1) begin
            nErr++; $display("FAIL timeout_fire cnt=%0d slots=%h tclr=%b exp cnt=0 slots=0 tclr=1",
                             inputCount, slots(), timeoutClr);
        end
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (timeoutClr) pulses++;
        end
        nCmp++;
        if (pulses !== 0) begin
            nErr++; $display("FAIL timeout_idle_zero pulses=%0d exp=0", pulses);
        end
`else
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (timeoutClr) pulses++;
        end
        nCmp++;
        if (inputCount !== 4'd2 || slots() !== 32'h2300_0000 || pulses !== 0) begin
            nErr++; $display("FAIL no_timeout cnt=%0d slots=%h pulses=%0d exp cnt=2 slots=23000000 pulses=0",
                             inputCount, slots(), pulses);
        end
`endif
    endtask

    task automatic test_rst_mid();
        doReset();
        for (int i = 0; i < 5; i++) pressDigit(4'd9);
        nCmp++;
        if (inputCount !== 4'd5) begin
            nErr++; $display("FAIL rst_mid_pre cnt=%0d exp=5", inputCount);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nCmp++;
        if (inputCount !== 4'd0 || slots() !== 32'h0 ||
            {entryDone, digitReject, timeoutClr} !== 3'b000) begin
            nErr++; $display("FAIL rst_mid cnt=%0d slots=%h pulses=%b exp cnt=0 slots=0 pulses=000",
                             inputCount, slots(), {entryDone, digitReject, timeoutClr});
        end
        tick();
        nCmp++;
        if ({entryDone, timeoutClr} !== 2'b00) begin
            nErr++; $display("FAIL rst_mid_after pulses=%b exp=00", {entryDone, timeoutClr});
        end
    endtask

    initial begin
        rst        = 1'b1;
        digitValid = 1'b0;
        digitValue = 4'd0;
        backspace  = 1'b0;
        clearEntry = 1'b0;
        resetCount = 1'b0;
        test_reset();
        test_fill();
        test_full();
        test_count3();
        test_reset_count();
        test_clear();
        test_timeout();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_entry.md
# digit_entry

Keypad digit collector sitting directly upstream of the unlocker. Accepts one decimal digit per strobe from the debounced keypad. Assembles a 4-digit username followed by a 4-digit password. Presents the digits and a running `inputCount` to the unlocker, and clears itself when the unlocker raises `resetCount`.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 100000000: idle cycles before a partial entry is discarded. Used only with `DIGIT_ENTRY_TIMEOUT_EN`.
- `TIMEOUT_W`, default 27: width of the idle counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

**Ports**
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `digitValid` in 1: one-cycle strobe; `digitValue` is valid.
- `digitValue` in 4: digit code; legal range 0–9.
- `backspace` in 1: one-cycle strobe; remove the last accepted digit.
- `clearEntry` in 1: one-cycle strobe; discard the whole entry.
- `resetCount` in 1: from the unlocker; level, discard the whole entry while high.
- `inputCount` out 4: number of digits held, 0–8.
- `userNameInput0`..`userNameInput3` out 4 each: username digits in entry order.
- `passwordInput0`..`passwordInput3` out 4 each: password digits in entry order.
- `entryDone` out 1: one-cycle pulse when the 8th digit is accepted.
- `digitReject` out 1: one-cycle pulse when a `digitValid` strobe is not accepted.
- `timeoutClr` out 1: one-cycle pulse when the idle timeout discards an entry.

## Operation

**State machine** (derived from the count register):
- USER: `inputCount` 0–3.
- PASS: `inputCount` 4–7.
- FULL: `inputCount` = 8.

**Accept digit**
- Condition: `digitValid`=1, `digitValue` ≤ 9, state ≠ FULL, and no higher-priority event.
- Action: write `digitValue` into slot `inputCount`. Slots 0–3 are `userNameInput0`–`3`; slots 4–7 are `passwordInput0`–`3`.
- Then increment `inputCount`.
- The transition 7→8 also pulses `entryDone`.

**Reject digit**
- Pulse `digitReject`, with no other change, when `digitValid`=1 and any of the following holds:
  - `digitValue` > 9;
  - state is FULL;
  - the strobe is pre-empted by a higher-priority event.

**Backspace**
- When `inputCount` > 0: decrement `inputCount` and zero the slot at the new count.
- When `inputCount` = 0: no-op; no reject pulse.
- Backspace from FULL returns the block to PASS (count 7).

**Clear**
- `clearEntry`, `resetCount`, or timeout set `inputCount` and all eight slots to 0.

**Priority** (highest first), one event per cycle:
1. `rst`
2. `resetCount`
3. `clearEntry`
4. timeout
5. `backspace`
6. `digitValid`

**Outputs**
- All outputs are registered. Digit and count outputs are never combinational from inputs.

## Timing

**Reset values**
- `inputCount`=0, all eight digit outputs=0, `entryDone`=0, `digitReject`=0, `timeoutClr`=0.
- Idle counter=0.

**Latency**
- A strobe sampled at edge N updates `inputCount` and the slot at edge N.
- The new values are visible in cycle N+1.
- `entryDone`, `digitReject` and `timeoutClr` are high for exactly cycle N+1.
- `entryDone` coincides with the first cycle `inputCount` reads 8.

**Strobe handling**
- Strobes are assumed single-cycle.
- A strobe held for k cycles is processed k times. This is the upstream debouncer's responsibility.

**`resetCount`**
- While `resetCount` is high, the block stays cleared; every `digitValid` pulses `digitReject`.

**Reset mid-entry**
- `rst` at any count returns the block to the reset values at that edge.
- No `entryDone` or `timeoutClr` pulse is produced.

## Configuration

**`DIGIT_ENTRY_TIMEOUT_EN` defined**
- The idle counter increments each cycle while `inputCount` > 0.
- It returns to 0 on any accepted digit, backspace, or clear, and whenever `inputCount` = 0.
- On the cycle the counter equals TIMEOUT_CYCLES−1, the entry is cleared: all slots and the count go to 0, and `timeoutClr` pulses next cycle.
- The FULL state also times out.

**Not defined**
- The counter logic is absent and `timeoutClr` is tied to 0.
- A partial entry persists indefinitely.

## Test plan

- Reset, then digits 0,0,1,1,0,0,1,1 on consecutive strobes:
  - `inputCount` steps 1..8;
  - username = 0,0,1,1 and password = 0,0,1,1;
  - `entryDone` high only in the cycle count first reads 8.
- From FULL:
  - digit 5 → `digitReject` pulse, count stays 8;
  - `backspace` → count 7 and `passwordInput3`=0;
  - digit 9 → count 8, `passwordInput3`=9, `entryDone` pulses again.
- At count 3:
  - `digitValue`=12 → `digitReject`, count stays 3;
  - `digitValid`+`backspace` in the same cycle → count 2, `userNameInput2`=0, `digitReject`=1.
- At count 6:
  - `resetCount` high for 3 cycles with a digit strobe in cycle 2 → count 0, all slots 0, one `digitReject`;
  - after release, digit 4 → `userNameInput0`=4, count 1.
- With `DIGIT_ENTRY_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10:
  - enter 2 digits, then idle → count 0 ten cycles after the last accept, `timeoutClr` one pulse;
  - at count 0, idle 50 cycles → no pulse.
- `rst` asserted at count 5 → all outputs 0 next cycle, no `entryDone` or `timeoutClr` pulse.
